// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - byte stream, load control and instruction-memory write bundle
interface instruction_loader_if;
    logic        load_start;
    logic [7:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        instruction_Write_en;
    logic [31:0] Write_address;
    logic [31:0] Write_instruction;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    modport master (
        output load_start, word_count, byte_valid, byte_data,
        input  byte_ready, instruction_Write_en, Write_address, Write_instruction,
               cpu_reset, load_done, load_error
    );

    modport slave (
        input  load_start, word_count, byte_valid, byte_data,
        output byte_ready, instruction_Write_en, Write_address, Write_instruction,
               cpu_reset, load_done, load_error
    );
endinterface

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream instruction loader; optional trailing XOR checksum via LOADER_CHECKSUM_EN
module instruction_loader #(
    parameter int MAX_WORDS = 200
) (
    input  logic               clk,
    input  logic               reset,
    instruction_loader_if.slave bus
);

    localparam logic [8:0] MAX_W = MAX_WORDS[8:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  count_q, count_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  addr_inc;
    logic        accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    // Outputs decode straight from the state so they change only on clock edges
`ifdef LOADER_CHECKSUM_EN
    assign bus.byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
`else
    assign bus.byte_ready = (state_q == S_RECV);
`endif
    assign bus.instruction_Write_en = (state_q == S_WRITE);
    assign bus.Write_address        = {24'd0, addr_q};
    assign bus.Write_instruction    = word_q;
    assign bus.cpu_reset            = (state_q != S_DONE);
    assign bus.load_done            = (state_q == S_DONE);
    assign bus.load_error           = (state_q == S_ERROR);

    assign accept   = bus.byte_valid && bus.byte_ready;
    assign addr_inc = addr_q + 8'd1;

    // State and datapath registers; reset overrides everything including a load in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 8'd0;
            count_q <= 8'd0;
            idx_q   <= 2'd0;
            word_q  <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        idx_d   = idx_q;
        word_d  = word_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // DONE and ERROR restart exactly like IDLE; busy states ignore load_start
                if (bus.load_start) begin
                    if (bus.word_count == 8'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, bus.word_count} > MAX_W) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_RECV;
                        addr_d  = 8'd0;
                        idx_d   = 2'd0;
                        count_d = bus.word_count;
`ifdef LOADER_CHECKSUM_EN
                        chk_d   = 8'd0;
`endif
                    end
                end
            end
            S_RECV: begin
                // Shift-in gives big-endian order: first byte ends up in bits 31:24
                if (accept) begin
                    word_d = {word_q[23:0], bus.byte_data};
                    idx_d  = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d  = chk_q ^ bus.byte_data;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_inc;
                if (addr_inc == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_d = (bus.byte_data == chk_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

endmodule
